inst_fetch_unit: RTL and testbench

Instruction fetch front end for the single-cycle RISC-V core pipeline variant. Sits between the program-counter stage and the decoder. It owns the fetch address, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers the returned words with their addresses in a small FIFO. It delivers them to decode over a valid/ready handshake and flushes cleanly when execute redirects the PC (branch/jump).

---
 rtl/inst_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: in-order instruction fetch front end.
// Tracks outstanding reads, buffers words, flushes on redirect.
module inst_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  input  logic        inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t ONE     = cnt_t'(1);
  localparam ptr_t PONE    = ptr_t'(1);

  logic [31:0] fetch_pc;
  cnt_t        out_cnt;
  cnt_t        drop_cnt;
  cnt_t        fifo_cnt;

  logic [31:0] aq_mem [DEPTH];
  ptr_t        aq_wr;
  ptr_t        aq_rd;

  logic [31:0] fq_pc   [DEPTH];
  logic [31:0] fq_inst [DEPTH];
  ptr_t        fq_wr;
  ptr_t        fq_rd;

  logic [CW:0] occ;
  logic        req_fire;
  logic        resp_ok;
  logic        resp_keep;
  logic        fq_push;
  logic        fq_pop;
  cnt_t        resp_dec;
  logic [1:0]  unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[1:0];

  // Issue gating, handshake decode and head presentation
  always_comb begin
    occ       = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    imem_req_valid = !rst && !redirect_valid
                   && (occ < {1'b0, DEPTH_C});
    imem_req_addr  = fetch_pc;
    req_fire  = imem_req_valid && imem_req_ready;
    // a response with nothing outstanding is ignored
    resp_ok   = imem_resp_valid && (out_cnt != '0);
    resp_dec  = resp_ok ? ONE : '0;
    resp_keep = resp_ok && (drop_cnt == '0)
              && !redirect_valid;
    inst_valid = (fifo_cnt != '0);
    inst_pc    = fq_pc[fq_rd];
    inst       = fq_inst[fq_rd];
    fq_push    = resp_keep;
    // redirect kills the presented instruction
    fq_pop     = inst_valid && inst_ready
               && !redirect_valid;
  end

  // Fetch address: redirect wins over sequential advance
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Outstanding request counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else begin
      unique case (1'b1)
        req_fire && !resp_ok: out_cnt <= out_cnt + ONE;
        !req_fire && resp_ok: out_cnt <= out_cnt - ONE;
        default: ;
      endcase
    end
  end

  // Count of in-flight responses to discard after a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= out_cnt - resp_dec;
    end else if (resp_ok && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - ONE;
    end
  end

  // Address queue: pairs each response with its request address
  always_ff @(posedge clk) begin
    if (rst) begin
      aq_wr <= '0;
      aq_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        aq_mem[i] <= '0;
      end
    end else begin
      if (req_fire) begin
        aq_mem[aq_wr] <= fetch_pc;
        aq_wr         <= aq_wr + PONE;
      end
      if (resp_ok) begin
        aq_rd <= aq_rd + PONE;
      end
    end
  end

  // Instruction FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fq_wr <= '0;
      fq_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fq_pc[i]   <= '0;
        fq_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      fq_wr <= '0;
      fq_rd <= '0;
    end else begin
      if (fq_push) begin
        fq_pc[fq_wr]   <= aq_mem[aq_rd];
        fq_inst[fq_wr] <= imem_resp_data;
        fq_wr          <= fq_wr + PONE;
      end
      if (fq_pop) begin
        fq_rd <= fq_rd + PONE;
      end
    end
  end

  // Instruction FIFO occupancy
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      fifo_cnt <= '0;
    end else begin
      unique case (1'b1)
        fq_push && !fq_pop: fifo_cnt <= fifo_cnt + ONE;
        !fq_push && fq_pop: fifo_cnt <= fifo_cnt - ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench for the fetch unit
// with a programmable-latency instruction memory model.
module tb_inst_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid),
    .inst_pc(inst_pc),
    .inst(inst),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // memory model: in-order, fixed latency, data = addr ^ KEY
  int          mem_lat = 1;
  int          cyc = 0;
  logic        mem_rv = 1'b0;
  logic [31:0] mem_rd = '0;
  logic        stray = 1'b0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  assign imem_resp_valid = mem_rv | stray;
  assign imem_resp_data  = mem_rd;

  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      mem_rv <= 1'b0;
      mem_rd <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + mem_lat);
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc + 1) begin
        mem_rv <= 1'b1;
        mem_rd <= q_addr[0] ^ KEY;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        mem_rv <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves time in cycle 0 after reset release
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    stray = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    repeat (2) tick();
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    end
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    end
    n_checks++;
    if (inst_pc !== 32'h0 || inst !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_inst: got pc %h inst %h want 0 0",
               inst_pc, inst);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got v%b %h want v1 00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    int          first;
    int          got;
    logic [31:0] exp_pc;
    first = -1;
    got = 0;
    exp_pc = 32'h0;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      #1;
      if (inst_valid === 1'b1) begin
        if (first < 0) first = c;
        n_checks++;
        if (inst_pc !== exp_pc || inst !== (exp_pc ^ KEY)) begin
          n_fail++;
          $display("FAIL stream_seq: got %h/%h want %h/%h",
                   inst_pc, inst, exp_pc, exp_pc ^ KEY);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    n_checks++;
    if (first != 2) begin
      n_fail++;
      $display("FAIL stream_first: got cycle %0d want 2", first);
    end
    n_checks++;
    if (got < 8) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want >= 8", got);
    end
  endtask

  task automatic test_req_stall();
    int          got;
    logic [31:0] exp_pc;
    got = 0;
    exp_pc = 32'h0;
    mem_lat = 1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0
          || inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got v%b %h iv%b want v1 0 iv0",
                 imem_req_valid, imem_req_addr, inst_valid);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (inst_valid === 1'b1) begin
        n_checks++;
        if (inst_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL stall_seq: got %h want %h",
                   inst_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    n_checks++;
    if (got < 4) begin
      n_fail++;
      $display("FAIL stall_resume: got %0d want >= 4", got);
    end
  endtask

  task automatic test_backpressure();
    int issued;
    issued = 0;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      #1;
      if (imem_req_valid && imem_req_ready) issued++;
      tick();
    end
    #1;
    n_checks++;
    if (issued != 2) begin
      n_fail++;
      $display("FAIL bp_issued: got %0d want 2", issued);
    end
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_req_off: got %b want 0", imem_req_valid);
    end
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_head: got v%b %h want v1 00000000",
               inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_second: got v%b %h want v1 00000004",
               inst_valid, inst_pc);
    end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL bp_resume: got v%b %h want v1 00000008",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect();
    bit seen_req;
    bit seen_inst;
    seen_req = 1'b0;
    seen_inst = 1'b0;
    mem_lat = 3;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_block: got %b want 0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (imem_req_valid === 1'b1 && !seen_req) begin
        seen_req = 1'b1;
        n_checks++;
        if (imem_req_addr !== 32'h0000_1000) begin
          n_fail++;
          $display("FAIL redir_addr: got %h want 00001000",
                   imem_req_addr);
        end
      end
      if (inst_valid === 1'b1 && !seen_inst) begin
        seen_inst = 1'b1;
        n_checks++;
        if (inst_pc !== 32'h1000 || inst !== (32'h1000 ^ KEY)) begin
          n_fail++;
          $display("FAIL redir_inst: got %h/%h want 00001000/%h",
                   inst_pc, inst, 32'h1000 ^ KEY);
        end
      end
      tick();
    end
    n_checks++;
    if (!seen_req || !seen_inst) begin
      n_fail++;
      $display("FAIL redir_timeout: got req%b inst%b want 1 1",
               seen_req, seen_inst);
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_collide();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL coll_pre: got v%b %h want v1 00000000",
               inst_valid, inst_pc);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_empty: got %b want 0", inst_valid);
    end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL coll_req: got v%b %h want v1 00000200",
               imem_req_valid, imem_req_addr);
    end
    tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_stale: got %b want 0", inst_valid);
    end
    tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200
        || inst !== (32'h200 ^ KEY)) begin
      n_fail++;
      $display("FAIL coll_new: got v%b %h/%h want v1 00000200/%h",
               inst_valid, inst_pc, inst, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req0: got v%b %h want v1 fffffffc",
               imem_req_valid, imem_req_addr);
    end
    tick();
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req1: got v%b %h want v1 00000000",
               imem_req_valid, imem_req_addr);
    end
    tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_inst0: got v%b %h want v1 fffffffc",
               inst_valid, inst_pc);
    end
    tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_inst1: got v%b %h want v1 00000000",
               inst_valid, inst_pc);
    end
  endtask

  task automatic test_mid_reset();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_req: got %b want 0", imem_req_valid);
    end
    tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_pc !== 32'h0
        || inst !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_state: got v%b %h/%h want v0 0/0",
               inst_valid, inst_pc, inst);
    end
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_req0: got v%b %h want v1 00000000",
               imem_req_valid, imem_req_addr);
    end
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_resp: got req%b iv%b want 1 0",
               imem_req_valid, inst_valid);
    end
    imem_req_ready = 1'b1;
    repeat (2) tick();
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL stray_recover: got v%b %h want v1 00000000",
               inst_valid, inst_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_req_stall();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
